// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer with 1-cycle multiply and 32-step restoring divide
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mf_req,
    input  logic        flush,
    output logic        op_ready,
    output logic        busy,
    output logic        stall_req,
    output logic        hi_wr,
    output logic        lo_wr,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [31:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d;
    logic kill, acc, sdiv;
    logic [31:0] abs_a, abs_b, quo, rem;
    logic [32:0] shl, diff;
    logic [63:0] prod;
    assign kill = flush || rst;
    assign op_ready = state_q == IDLE;
    assign busy = !op_ready;
    assign acc = op_valid && op_ready && !kill && op != 3'b000 && op != 3'b111;
    assign stall_req = !kill && ((op_valid && op != 3'b000 && op != 3'b111 && !op_ready) || (mf_req && busy));
    assign sdiv = op == 3'b011;
    assign abs_a = (sdiv && rs_data[31]) ? -rs_data : rs_data;
    assign abs_b = (sdiv && rt_data[31]) ? -rt_data : rt_data;
    assign prod = {{32{sgn_q & q_q[31]}}, q_q} * {{32{sgn_q & d_q[31]}}, d_q};
    // q_q shifts dividend bits out at the top while quotient bits enter at the bottom
    assign shl = {r_q, q_q[31]};
    assign diff = shl - {1'b0, d_q};
    assign quo = neg_q ? -q_q : q_q;
    assign rem = rneg_q ? -r_q : r_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        q_d = q_q;
        r_d = r_q;
        d_d = d_q;
        sgn_d = sgn_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        hi_wdata = '0;
        lo_wdata = '0;
        case (state_q)
            IDLE: if (acc) begin
                if (op == 3'b101) begin
                    hi_wr = 1'b1;
                    hi_wdata = rs_data;
                end else if (op == 3'b110) begin
                    lo_wr = 1'b1;
                    lo_wdata = rs_data;
                end else if (op <= 3'b010) begin
                    state_d = MUL;
                    q_d = rs_data;
                    d_d = rt_data;
                    sgn_d = op == 3'b001;
                end else if (rt_data == '0) begin
                    state_d = DONE;
                    q_d = '1;
                    r_d = rs_data;
                    neg_d = 1'b0;
                    rneg_d = 1'b0;
                end else begin
                    state_d = DIV;
                    cnt_d = '0;
                    q_d = abs_a;
                    d_d = abs_b;
                    r_d = '0;
                    neg_d = sdiv && (rs_data[31] ^ rt_data[31]);
                    rneg_d = sdiv && rs_data[31];
                end
            end
            MUL: begin
                state_d = IDLE;
                hi_wr = !kill;
                lo_wr = !kill;
                hi_wdata = kill ? '0 : prod[63:32];
                lo_wdata = kill ? '0 : prod[31:0];
            end
            DIV: begin
                q_d = {q_q[30:0], !diff[32]};
                r_d = diff[32] ? shl[31:0] : diff[31:0];
                cnt_d = cnt_q + 6'd1;
                state_d = kill ? IDLE : (cnt_q == 6'd31 ? DONE : DIV);
            end
            DONE: begin
                state_d = IDLE;
                hi_wr = !kill;
                lo_wr = !kill;
                hi_wdata = kill ? '0 : rem;
                lo_wdata = kill ? '0 : quo;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            q_q <= q_d;
            r_q <= r_d;
            d_q <= d_d;
            sgn_q <= sgn_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_valid = 1'b0;
    logic [2:0] op = 3'b000;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic mf_req = 1'b0;
    logic flush = 1'b0;
    logic op_ready, busy, stall_req, hi_wr, lo_wr;
    logic [31:0] hi_wdata, lo_wdata;
    int pass_cnt = 0;
    int tot_cnt = 0;
    int wr_cnt = 0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .mf_req(mf_req), .flush(flush), .op_ready(op_ready), .busy(busy), .stall_req(stall_req),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (hi_wr || lo_wr) wr_cnt++;

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        step();
        op_valid = 1'b0;
        op = 3'b000;
        #1;
    endtask

    task automatic wait_wr(output int n);
        n = 1;
        while (!(hi_wr || lo_wr) && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset;
        op_valid = 1'b1;
        op = 3'b101;
        rs_data = 32'h1111_2222;
        step();
        step();
        tot_cnt++; if (op_ready !== 1'b1) $display("FAIL rst_op_ready got=%b exp=1", op_ready); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
        tot_cnt++; if (stall_req !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall_req); else pass_cnt++;
        tot_cnt++; if ({hi_wr, lo_wr} !== 2'b00) $display("FAIL rst_wr got=%b exp=00", {hi_wr, lo_wr}); else pass_cnt++;
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'h0) $display("FAIL rst_wdata got=%h exp=0", {hi_wdata, lo_wdata}); else pass_cnt++;
        op_valid = 1'b0;
        op = 3'b000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_mult;
        int n;
        mf_req = 1'b1;
        #1;
        tot_cnt++; if (stall_req !== 1'b0) $display("FAIL mf_idle_stall got=%b exp=0", stall_req); else pass_cnt++;
        mf_req = 1'b0;
        issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_wr(n);
        tot_cnt++; if (n !== 1) $display("FAIL mult_latency got=%0d exp=1", n); else pass_cnt++;
        tot_cnt++; if ({hi_wr, lo_wr} !== 2'b11) $display("FAIL mult_wr got=%b exp=11", {hi_wr, lo_wr}); else pass_cnt++;
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_val got=%h exp=FFFFFFFFFFFFFFFA", {hi_wdata, lo_wdata}); else pass_cnt++;
        step();
        tot_cnt++; if (op_ready !== 1'b1) $display("FAIL mult_ready got=%b exp=1", op_ready); else pass_cnt++;
        issue(3'b010, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_wr(n);
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'h0000_0002_FFFF_FFFA) $display("FAIL multu_val got=%h exp=00000002FFFFFFFA", {hi_wdata, lo_wdata}); else pass_cnt++;
        step();
        issue(3'b001, 32'd5, 32'd6);
        flush = 1'b1;
        #1;
        tot_cnt++; if ({hi_wr, lo_wr} !== 2'b00) $display("FAIL mult_flush_wr got=%b exp=00", {hi_wr, lo_wr}); else pass_cnt++;
        step();
        flush = 1'b0;
        #1;
    endtask

    task automatic test_div;
        int n;
        issue(3'b011, 32'hFFFF_FFF9, 32'd2);
        tot_cnt++; if (busy !== 1'b1) $display("FAIL div_busy got=%b exp=1", busy); else pass_cnt++;
        wait_wr(n);
        tot_cnt++; if (n !== 33) $display("FAIL div_latency got=%0d exp=33", n); else pass_cnt++;
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg7_2 got=%h exp=FFFFFFFFFFFFFFFD", {hi_wdata, lo_wdata}); else pass_cnt++;
        step();
        tot_cnt++; if (op_ready !== 1'b1) $display("FAIL div_ready got=%b exp=1", op_ready); else pass_cnt++;
        issue(3'b100, 32'd100, 32'd7);
        wait_wr(n);
        tot_cnt++; if ({hi_wdata, lo_wdata} !== {32'd2, 32'd14}) $display("FAIL divu_100_7 got=%h exp=%h", {hi_wdata, lo_wdata}, {32'd2, 32'd14}); else pass_cnt++;
        step();
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_wr(n);
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'h0000_0000_8000_0000) $display("FAIL div_ovf got=%h exp=0000000080000000", {hi_wdata, lo_wdata}); else pass_cnt++;
        step();
    endtask

    task automatic test_div_zero;
        int n;
        issue(3'b100, 32'h1234_5678, 32'd0);
        wait_wr(n);
        tot_cnt++; if (n !== 1) $display("FAIL divz_latency got=%0d exp=1", n); else pass_cnt++;
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'h1234_5678_FFFF_FFFF) $display("FAIL divuz_val got=%h exp=12345678FFFFFFFF", {hi_wdata, lo_wdata}); else pass_cnt++;
        step();
        issue(3'b011, 32'h8000_0000, 32'd0);
        wait_wr(n);
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'h8000_0000_FFFF_FFFF) $display("FAIL divz_val got=%h exp=80000000FFFFFFFF", {hi_wdata, lo_wdata}); else pass_cnt++;
        step();
    endtask

    task automatic test_flush;
        int w0;
        op_valid = 1'b1;
        op = 3'b101;
        rs_data = 32'h77;
        flush = 1'b1;
        #1;
        tot_cnt++; if (hi_wr !== 1'b0) $display("FAIL flush_idle_mthi got=%b exp=0", hi_wr); else pass_cnt++;
        op_valid = 1'b0;
        flush = 1'b0;
        w0 = wr_cnt;
        issue(3'b011, 32'd1000, 32'd3);
        repeat (9) step();
        flush = 1'b1;
        mf_req = 1'b1;
        op_valid = 1'b1;
        op = 3'b011;
        #1;
        tot_cnt++; if (stall_req !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall_req); else pass_cnt++;
        step();
        flush = 1'b0;
        mf_req = 1'b0;
        op_valid = 1'b0;
        op = 3'b000;
        #1;
        tot_cnt++; if (op_ready !== 1'b1) $display("FAIL flush_ready got=%b exp=1", op_ready); else pass_cnt++;
        tot_cnt++; if (wr_cnt !== w0) $display("FAIL flush_nowrite got=%0d exp=%0d", wr_cnt, w0); else pass_cnt++;
        op_valid = 1'b1;
        op = 3'b110;
        rs_data = 32'hA5;
        #1;
        tot_cnt++; if ({hi_wr, lo_wr, lo_wdata} !== {2'b01, 32'hA5}) $display("FAIL mtlo got=%h exp=%h", {hi_wr, lo_wr, lo_wdata}, {2'b01, 32'hA5}); else pass_cnt++;
        step();
        op_valid = 1'b0;
        op = 3'b000;
        #1;
    endtask

    task automatic test_stall;
        int bad = 0;
        issue(3'b011, 32'd100, 32'd7);
        mf_req = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (c == 5) begin
                op_valid = 1'b1;
                op = 3'b011;
                rs_data = 32'd9;
                rt_data = 32'd3;
            end
            #1;
            if (stall_req !== 1'b1) bad++;
            if (c == 33) begin
                tot_cnt++; if ({hi_wr, lo_wr, hi_wdata, lo_wdata} !== {2'b11, 32'd2, 32'd14}) $display("FAIL stall_div_val got=%h exp=%h", {hi_wr, lo_wr, hi_wdata, lo_wdata}, {2'b11, 32'd2, 32'd14}); else pass_cnt++;
            end
            op_valid = 1'b0;
            op = 3'b000;
            step();
        end
        tot_cnt++; if (bad !== 0) $display("FAIL stall_busy got=%0d_bad_cycles exp=0", bad); else pass_cnt++;
        tot_cnt++; if ({stall_req, op_ready} !== 2'b01) $display("FAIL stall_after got=%b exp=01", {stall_req, op_ready}); else pass_cnt++;
        step();
        tot_cnt++; if (busy !== 1'b0) $display("FAIL second_div_ignored got=%b exp=0", busy); else pass_cnt++;
        mf_req = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back;
        int n;
        issue(3'b100, 32'd50, 32'd5);
        wait_wr(n);
        step();
        op_valid = 1'b1;
        op = 3'b101;
        rs_data = 32'hDEAD_BEEF;
        #1;
        tot_cnt++; if ({hi_wr, hi_wdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL b2b_mthi got=%h exp=%h", {hi_wr, hi_wdata}, {1'b1, 32'hDEAD_BEEF}); else pass_cnt++;
        step();
        issue(3'b010, 32'd7, 32'd6);
        wait_wr(n);
        step();
        issue(3'b010, 32'd9, 32'd9);
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'd81) $display("FAIL b2b_mult got=%h exp=%h", {hi_wdata, lo_wdata}, 64'd81); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_div;
        int w0;
        w0 = wr_cnt;
        issue(3'b100, 32'd100, 32'd7);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        tot_cnt++; if ({op_ready, busy, stall_req, hi_wr, lo_wr} !== 5'b10000) $display("FAIL rstdiv_ctl got=%b exp=10000", {op_ready, busy, stall_req, hi_wr, lo_wr}); else pass_cnt++;
        tot_cnt++; if ({hi_wdata, lo_wdata} !== 64'h0) $display("FAIL rstdiv_wdata got=%h exp=0", {hi_wdata, lo_wdata}); else pass_cnt++;
        repeat (35) step();
        tot_cnt++; if (wr_cnt !== w0) $display("FAIL rstdiv_nowrite got=%0d exp=%0d", wr_cnt, w0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: op_valid  in  1  operation request from EX stage.
REQ-004 SHALL: op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-005 SHALL: rs_data, rt_data  in  32 each  operands; MTHI/MTLO source is rs_data.
REQ-006 SHALL: mf_req  in  1  MFHI/MFLO in EX needs HI/LO.
REQ-007 SHALL: flush  in  1  kill in-flight operation (exception/eret).
REQ-008 SHALL: op_ready  out  1  high only in IDLE.
REQ-009 SHALL: busy  out  1  high in any non-IDLE state.
REQ-010 SHALL: stall_req  out  1  pipeline stall request.
REQ-011 SHALL: hi_wr, lo_wr  out  1 each  write strobes to the HI/LO register pair.
REQ-012 SHALL: hi_wdata, lo_wdata  out  32 each  write data; 0 when the matching strobe is low.

Function
REQ-013 SHALL: states IDLE, MUL, DIV, DONE; operation accepted when op_valid && op_ready && !flush && op is 001..110.
REQ-014 SHALL: MTHI/MTLO accepted in IDLE drive hi_wr (resp. lo_wr)=1 with data rs_data in the same cycle, combinationally; state stays IDLE.
REQ-015 SHALL: MULT/MULTU acceptance registers operands and signedness, IDLE->MUL; in MUL, hi_wr=lo_wr=1 with {hi,lo}=64-bit product (signed for MULT), then MUL->IDLE; latency 1 cycle.
REQ-016 SHALL: DIV/DIVU with rt_data!=0: IDLE->DIV; 32 cycles of radix-2 restoring division on magnitudes, 6-bit counter 0..31; after count 31, DIV->DONE.
REQ-017 SHALL: in DONE, lo_wr=hi_wr=1, LO=quotient, HI=remainder, then DONE->IDLE; accept-to-write latency 33 cycles.
REQ-018 SHALL: signed DIV: quotient negated when operand signs differ, remainder takes sign of dividend; 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-019 SHALL: divide by zero (rt_data==0): IDLE->DONE directly, LO=0xFFFFFFFF, HI=rs_data, for DIV and DIVU.
REQ-020 SHALL: op_valid while busy is ignored (not queued); stall_req=(op_valid && op!=none && !op_ready) || (mf_req && busy).
REQ-021 SHALL: flush in MUL, DIV or DONE forces next state IDLE and suppresses hi_wr/lo_wr in that cycle; flush in IDLE suppresses acceptance including MTHI/MTLO.
REQ-022 SHALL: stall_req is never asserted when flush is high.
REQ-023 SHALL: an operation accepted in the cycle the state returns to IDLE is legal (back-to-back); MTHI in the cycle after DONE overrides HI.
REQ-024 SHALL: mf_req in IDLE never stalls; HI/LO read-after-write forwarding is outside this block.

Reset
REQ-025 SHALL: rst forces IDLE, counter 0, operand/partial registers 0; outputs op_ready=1, busy=0, stall_req=0, hi_wr=lo_wr=0, wdata=0.
REQ-026 SHALL: rst mid-division aborts with no HI/LO write; rst has priority over flush and op_valid.

Verification
REQ-027 SHALL: MULT rs=0xFFFFFFFE, rt=0x00000003 -> next cycle hi_wr=lo_wr=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-028 SHALL: DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 33 cycles, write at cycle 33 LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-029 SHALL: DIVU rs=0x12345678, rt=0 -> one cycle later LO=0xFFFFFFFF, HI=0x12345678.
REQ-030 SHALL: DIV issued, flush at cycle 10 -> no write ever, op_ready=1 at cycle 11; new MTLO rs=0xA5 then writes LO=0xA5 same cycle.
REQ-031 SHALL: during DIV, mf_req=1 -> stall_req=1 every cycle through DONE, 0 the cycle after; second DIV during busy -> stall_req=1, not accepted.
REQ-032 SHALL: rst asserted at DIV cycle 5 -> next cycle IDLE, no write, all outputs at reset values.
